// File: rtl/dplbuf_pkg.sv
// Shared types and constants for the LE-to-PCIE DPLBUF pipeline and its per-port trackers.
package dplbuf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        XFER    = 2'd2
    } port_st_e;

    localparam int ERR_UNSOL  = 0;
    localparam int ERR_DGNT   = 1;
    localparam int ERR_COLL   = 2;
    localparam int ERR_W      = 3;
    localparam int COLL_CNT_W = 16;

    function automatic int cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/dplbuf_port_trk.sv
// Per-port grant/burst tracker: state machine, beat counter, request mask and
// single-cycle protocol-violation pulses (double grant, unsolicited data).
module dplbuf_port_trk
    import dplbuf_pkg::*;
#(
    parameter int BURST = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_gnt,
    input  logic i_dv,
    input  logic i_req,
    output logic o_busy,
    output logic o_req_m,
    output logic o_dgnt,
    output logic o_unsol
);

    localparam int CW = cnt_w(BURST);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    port_st_e        r_state;
    port_st_e        w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_final;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_final     = 1'b0;
        o_dgnt      = 1'b0;
        o_unsol     = 1'b0;
        case (r_state)
            IDLE: begin
                o_unsol = i_dv;
                if (i_gnt) w_state_nxt = GRANTED;
            end
            GRANTED: begin
                if (i_dv) begin
                    if (BURST == 1) begin
                        w_final     = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = XFER;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            XFER: begin
                if (i_dv) begin
                    if (r_cnt == LAST) begin
                        w_final     = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A grant landing on the closing beat starts the next burst; anywhere else in a burst it is ignored and flagged.
        if (i_gnt && (r_state != IDLE)) begin
            if (w_final) w_state_nxt = GRANTED;
            else         o_dgnt      = 1'b1;
        end
    end

    assign o_busy  = (r_state != IDLE);
    assign o_req_m = i_req & (r_state == IDLE) & ~i_gnt;

endmodule

// File: rtl/dplbuf_pipe_trk.sv
// LE-to-PCIE DPLBUF pipeline: OR-merge of link data over STAGES registers with BIST merged at the last one,
// per-port request/grant tracking. Error reporting is compiled in only when DPLBUF_PIPE_CHK_EN is defined.
module dplbuf_pipe_trk
    import dplbuf_pkg::*;
#(
    parameter int PORTS  = 12,
    parameter int DW     = 256,
    parameter int STAGES = 2,
    parameter int BURST  = 8
) (
    input  logic                        iCLK,
    input  logic                        iRST_n,
    input  logic [PORTS-1:0][DW-1:0]    iLE_DPLBUF_DATA,
    input  logic [PORTS-1:0]            iLE_DPLBUF_REQ,
    input  logic [PORTS-1:0]            iLE_DPLBUF_DATA_V,
    input  logic [DW-1:0]               iBIST_DPLBUF_DATA,
    input  logic [PORTS-1:0]            iBIST_DPLBUF_REQ,
    input  logic [PORTS-1:0]            iBIST_DPLBUF_DATA_V,
    input  logic [PORTS-1:0]            iPCIE_DPLBUF_GNT,
    input  logic                        iERR_CLR,
    output logic [DW-1:0]               oPCIE_DPLBUF_DATA,
    output logic [PORTS-1:0]            oPCIE_DPLBUF_DATA_V,
    output logic [PORTS-1:0]            oPCIE_DPLBUF_REQ,
    output logic [PORTS-1:0]            oDAT_DPLBUF_GNT,
    output logic                        oDPLBUF_ANY_DATA_VLD,
    output logic [PORTS-1:0]            oDPLBUF_BUSY,
    output logic [ERR_W-1:0]            oDPLBUF_ERR,
    output logic [COLL_CNT_W-1:0]       oDPLBUF_COLL_CNT
);

    logic [DW-1:0]      w_le_or;
    logic [PORTS-1:0]   w_req_m;
    logic [PORTS-1:0]   w_busy;
    logic [PORTS-1:0]   w_dgnt;
    logic [PORTS-1:0]   w_unsol;
    logic [PORTS-1:0]   r_gnt;
    logic               r_any_vld;

    always_comb begin
        w_le_or = '0;
        for (int p = 0; p < PORTS; p++) w_le_or = w_le_or | iLE_DPLBUF_DATA[p];
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_trk
        dplbuf_port_trk #(.BURST(BURST)) u_trk (
            .i_clk   (iCLK),
            .i_rst_n (iRST_n),
            .i_gnt   (iPCIE_DPLBUF_GNT[p]),
            .i_dv    (iLE_DPLBUF_DATA_V[p]),
            .i_req   (iLE_DPLBUF_REQ[p]),
            .o_busy  (w_busy[p]),
            .o_req_m (w_req_m[p]),
            .o_dgnt  (w_dgnt[p]),
            .o_unsol (w_unsol[p])
        );
    end

    // Stage k takes the link-side merge (k==0) or the previous stage; the last stage also ORs in BIST.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [DW-1:0]    w_d;
        logic [PORTS-1:0] w_v;
        logic [PORTS-1:0] w_r;
        logic [DW-1:0]    r_data;
        logic [PORTS-1:0] r_dv;
        logic [PORTS-1:0] r_req;

        if (k == 0) begin : g_first
            assign w_d = w_le_or;
            assign w_v = iLE_DPLBUF_DATA_V;
            assign w_r = w_req_m;
        end else begin : g_next
            assign w_d = g_stage[k-1].r_data;
            assign w_v = g_stage[k-1].r_dv;
            assign w_r = g_stage[k-1].r_req;
        end

        if (k == STAGES - 1) begin : g_last
            always_ff @(posedge iCLK) begin
                r_data <= w_d | iBIST_DPLBUF_DATA;
            end
            always_ff @(posedge iCLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    r_dv  <= '0;
                    r_req <= '0;
                end else begin
                    r_dv  <= w_v | iBIST_DPLBUF_DATA_V;
                    r_req <= w_r | iBIST_DPLBUF_REQ;
                end
            end
        end else begin : g_pass
            always_ff @(posedge iCLK) begin
                r_data <= w_d;
            end
            always_ff @(posedge iCLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    r_dv  <= '0;
                    r_req <= '0;
                end else begin
                    r_dv  <= w_v;
                    r_req <= w_r;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_gnt     <= '0;
            r_any_vld <= 1'b0;
        end else begin
            r_gnt     <= iPCIE_DPLBUF_GNT;
            r_any_vld <= |iLE_DPLBUF_DATA_V;
        end
    end

    assign oPCIE_DPLBUF_DATA    = g_stage[STAGES-1].r_data;
    assign oPCIE_DPLBUF_DATA_V  = g_stage[STAGES-1].r_dv;
    assign oPCIE_DPLBUF_REQ     = g_stage[STAGES-1].r_req;
    assign oDAT_DPLBUF_GNT      = r_gnt;
    assign oDPLBUF_ANY_DATA_VLD = r_any_vld;
    assign oDPLBUF_BUSY         = w_busy;

`ifdef DPLBUF_PIPE_CHK_EN
    logic                  w_coll;
    logic [ERR_W-1:0]      w_err_set;
    logic [ERR_W-1:0]      r_err;
    logic [COLL_CNT_W-1:0] r_coll_cnt;

    // Clearing bit-hack: nonzero after removing the lowest set bit means two or more valids.
    assign w_coll              = |(iLE_DPLBUF_DATA_V & (iLE_DPLBUF_DATA_V - PORTS'(1)));
    assign w_err_set[ERR_COLL]  = w_coll;
    assign w_err_set[ERR_DGNT]  = |w_dgnt;
    assign w_err_set[ERR_UNSOL] = |w_unsol;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_err      <= '0;
            r_coll_cnt <= '0;
        end else if (iERR_CLR) begin
            r_err      <= w_err_set;
            r_coll_cnt <= COLL_CNT_W'(w_coll);
        end else begin
            r_err <= r_err | w_err_set;
            if (w_coll && (r_coll_cnt != '1)) r_coll_cnt <= r_coll_cnt + COLL_CNT_W'(1);
        end
    end

    assign oDPLBUF_ERR      = r_err;
    assign oDPLBUF_COLL_CNT = r_coll_cnt;
`else
    logic w_unused_chk;
    assign w_unused_chk     = ^{iERR_CLR, w_dgnt, w_unsol};
    assign oDPLBUF_ERR      = '0;
    assign oDPLBUF_COLL_CNT = '0;
`endif

endmodule

// File: tb/tb_dplbuf_pipe_trk.sv
// Scoreboard bench for dplbuf_pipe_trk (PORTS=12, DW=32, STAGES=2, BURST=4); error expectations follow DPLBUF_PIPE_CHK_EN.
module tb_dplbuf_pipe_trk;

    localparam int PORTS  = 12;
    localparam int DW     = 32;
    localparam int STAGES = 2;
    localparam int BURST  = 4;
`ifdef DPLBUF_PIPE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [PORTS-1:0][DW-1:0] le_data;
    logic [PORTS-1:0]         le_req, le_dv, bist_req, bist_dv, gnt;
    logic [DW-1:0]            bist_data;
    logic                     err_clr;
    logic [DW-1:0]            o_data;
    logic [PORTS-1:0]         o_dv, o_req, o_gnt, o_busy;
    logic                     o_any;
    logic [2:0]               o_err;
    logic [15:0]              o_cnt;

    typedef struct packed {
        logic [PORTS-1:0] dv;
        logic [DW-1:0]    data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dplbuf_pipe_trk #(.PORTS(PORTS), .DW(DW), .STAGES(STAGES), .BURST(BURST)) dut (
        .iCLK                 (clk),
        .iRST_n               (rst_n),
        .iLE_DPLBUF_DATA      (le_data),
        .iLE_DPLBUF_REQ       (le_req),
        .iLE_DPLBUF_DATA_V    (le_dv),
        .iBIST_DPLBUF_DATA    (bist_data),
        .iBIST_DPLBUF_REQ     (bist_req),
        .iBIST_DPLBUF_DATA_V  (bist_dv),
        .iPCIE_DPLBUF_GNT     (gnt),
        .iERR_CLR             (err_clr),
        .oPCIE_DPLBUF_DATA    (o_data),
        .oPCIE_DPLBUF_DATA_V  (o_dv),
        .oPCIE_DPLBUF_REQ     (o_req),
        .oDAT_DPLBUF_GNT      (o_gnt),
        .oDPLBUF_ANY_DATA_VLD (o_any),
        .oDPLBUF_BUSY         (o_busy),
        .oDPLBUF_ERR          (o_err),
        .oDPLBUF_COLL_CNT     (o_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        le_data   = '0;
        le_req    = '0;
        le_dv     = '0;
        bist_data = '0;
        bist_req  = '0;
        bist_dv   = '0;
        gnt       = '0;
        err_clr   = 1'b0;
    endtask

    task automatic push(input logic [PORTS-1:0] dv, input logic [DW-1:0] d);
        exp_t e;
        e.dv   = dv;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic grant(input int p);
        set_idle();
        gnt[p] = 1'b1;
        step();
    endtask

    task automatic drive_beat(input int p, input logic [DW-1:0] d, input bit g);
        set_idle();
        le_dv[p]   = 1'b1;
        le_data[p] = d;
        gnt[p]     = g;
        push(PORTS'(1) << p, d);
        step();
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dv"},   64'(o_dv),   64'h0);
        chk({tag, "_req"},  64'(o_req),  64'h0);
        chk({tag, "_gnt"},  64'(o_gnt),  64'h0);
        chk({tag, "_any"},  64'(o_any),  64'h0);
        chk({tag, "_busy"}, 64'(o_busy), 64'h0);
        chk({tag, "_err"},  64'(o_err),  64'h0);
        chk({tag, "_cnt"},  64'(o_cnt),  64'h0);
    endtask

    // Monitor: every presented valid must match the oldest expected beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_dv !== '0) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected: got dv %0h data %0h expected none", o_dv, o_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 64'(o_data), 64'(e.data));
                    chk("sb_dv",   64'(o_dv),   64'(e.dv));
                end
            end
        end
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Port 3: request, grant, four beats; request stays masked while granted.
        set_idle(); le_req[3] = 1'b1; step();
        set_idle(); le_req[3] = 1'b1; gnt[3] = 1'b1; step();
        chk("p3_req_unmasked", 64'(o_req[3]), 64'h1);
        chk("p3_gnt_back",     64'(o_gnt),    64'h008);
        chk("p3_busy_grant",   64'(o_busy[3]), 64'h1);
        for (int b = 0; b < BURST; b++) begin
            set_idle();
            le_req[3]  = 1'b1;
            le_dv[3]   = 1'b1;
            le_data[3] = 32'hA5A5_A5A0 + DW'(b);
            push(12'h008, 32'hA5A5_A5A0 + DW'(b));
            step();
            chk("p3_req_masked", 64'(o_req[3]),  64'h0);
            chk("p3_busy",       64'(o_busy[3]), (b < BURST - 1) ? 64'h1 : 64'h0);
            chk("p3_any_vld",    64'(o_any),     64'h1);
        end
        idle_cycles(3);

        // Port 5: grant coincides with the final beat and re-arms the port.
        grant(5);
        for (int b = 0; b < BURST - 1; b++) drive_beat(5, 32'h5500_0001 + DW'(b), 1'b0);
        drive_beat(5, 32'h5500_0004, 1'b1);
        chk("p5_regrant_busy", 64'(o_busy[5]), 64'h1);
        chk("p5_regrant_err",  64'(o_err),     64'h0);
        for (int b = 0; b < BURST; b++) drive_beat(5, 32'h5500_0010 + DW'(b), 1'b0);
        chk("p5_done_busy", 64'(o_busy[5]), 64'h0);
        chk("p5_done_err",  64'(o_err),     64'h0);
        idle_cycles(3);

        // Collisions on idle ports 0 and 7 (also unsolicited).
        for (int i = 0; i < 3; i++) begin
            set_idle();
            le_dv      = 12'h081;
            le_data[0] = 32'h0000_0001;
            le_data[7] = 32'h0000_0080;
            push(12'h081, 32'h0000_0081);
            step();
        end
        chk("coll_err", 64'(o_err), CHK ? 64'h5 : 64'h0);
        chk("coll_cnt", 64'(o_cnt), CHK ? 64'h3 : 64'h0);
        set_idle(); err_clr = 1'b1; step();
        chk("clr_err", 64'(o_err), 64'h0);
        chk("clr_cnt", 64'(o_cnt), 64'h0);
        set_idle();
        err_clr    = 1'b1;
        le_dv      = 12'h081;
        le_data[0] = 32'h0000_0001;
        le_data[7] = 32'h0000_0080;
        push(12'h081, 32'h0000_0081);
        step();
        chk("clr_vs_coll_err", 64'(o_err), CHK ? 64'h5 : 64'h0);
        chk("clr_vs_coll_cnt", 64'(o_cnt), CHK ? 64'h1 : 64'h0);
        set_idle(); err_clr = 1'b1; step();
        idle_cycles(3);

        // Unsolicited beat on port 2, then a double grant.
        set_idle();
        le_dv[2]   = 1'b1;
        le_data[2] = 32'h0000_0022;
        push(12'h004, 32'h0000_0022);
        step();
        chk("unsol_err", 64'(o_err), CHK ? 64'h1 : 64'h0);
        set_idle(); err_clr = 1'b1; step();
        chk("unsol_clr", 64'(o_err), 64'h0);
        grant(2);
        chk("p2_busy", 64'(o_busy[2]), 64'h1);
        grant(2);
        chk("dgnt_err",  64'(o_err),     CHK ? 64'h2 : 64'h0);
        chk("dgnt_busy", 64'(o_busy[2]), 64'h1);
        for (int b = 0; b < BURST; b++) drive_beat(2, 32'h2200_0000 + DW'(b), 1'b0);
        chk("p2_done_busy", 64'(o_busy[2]), 64'h0);
        set_idle(); err_clr = 1'b1; step();
        idle_cycles(3);

        // Reset in the middle of a port-9 burst, then a clean burst.
        grant(9);
        for (int b = 0; b < 2; b++) begin
            set_idle();
            le_dv[9]   = 1'b1;
            le_data[9] = 32'h9900_0000 + DW'(b);
            step();
        end
        rst_n = 1'b0;
        set_idle();
        step();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        step();
        grant(9);
        for (int b = 0; b < BURST; b++) drive_beat(9, 32'h9900_0010 + DW'(b), 1'b0);
        chk("p9_done_busy", 64'(o_busy[9]), 64'h0);
        chk("p9_done_err",  64'(o_err),     64'h0);
        idle_cycles(3);

        // BIST alone, then BIST merged with an LE beat two cycles in flight.
        set_idle();
        bist_dv[1]  = 1'b1;
        bist_req[1] = 1'b1;
        bist_data   = 32'h0000_1234;
        push(12'h002, 32'h0000_1234);
        step();
        chk("bist_req", 64'(o_req), 64'h002);
        idle_cycles(2);
        grant(4);
        set_idle();
        le_dv[4]   = 1'b1;
        le_data[4] = 32'h0000_4400;
        push(12'h012, 32'h0000_5634);
        step();
        set_idle();
        bist_dv[1] = 1'b1;
        bist_data  = 32'h0000_1234;
        step();
        for (int b = 1; b < BURST; b++) drive_beat(4, 32'h0000_4400 + DW'(b), 1'b0);
        chk("p4_done_busy", 64'(o_busy[4]), 64'h0);
        chk("final_err",    64'(o_err),     64'h0);
        idle_cycles(4);

        chk("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dplbuf_pipe_trk.md
# dplbuf_pipe_trk

Parametrised next-generation pipeline between the Link Engines and the PCIE DPLBUF interface. It OR-merges per-link DPLBUF data onto one bus through a configurable number of register stages, merges BIST traffic at the final stage, and tracks each port's request/grant/burst state. Requests are suppressed while a port already holds a grant, and protocol violations can optionally be reported.

## Interface
- PORTS, 12, number of link/port channels (1..16)
- DW, 256, data bus width in bits
- STAGES, 2, LE-to-PCIE pipeline depth for data/data_v/req (1..4)
- BURST, 8, data beats per grant (1..255)

- iCLK  input  1  clock
- iRST_n  input  1  asynchronous active-low reset
- iLE_DPLBUF_DATA  input  [PORTS-1:0][DW-1:0]  per-link data, zero when inactive
- iLE_DPLBUF_REQ  input  PORTS  per-port transfer request
- iLE_DPLBUF_DATA_V  input  PORTS  per-port data valid
- iBIST_DPLBUF_DATA  input  DW  BIST data, zero when inactive
- iBIST_DPLBUF_REQ  input  PORTS  BIST request
- iBIST_DPLBUF_DATA_V  input  PORTS  BIST data valid
- iPCIE_DPLBUF_GNT  input  PORTS  PCIE grant pulse, one cycle per burst
- iERR_CLR  input  1  clears sticky errors and collision count
- oPCIE_DPLBUF_DATA  output  DW  merged data
- oPCIE_DPLBUF_DATA_V  output  PORTS  merged valid
- oPCIE_DPLBUF_REQ  output  PORTS  merged, masked request
- oDAT_DPLBUF_GNT  output  PORTS  grant registered back to Link Engines
- oDPLBUF_ANY_DATA_VLD  output  1  any LE data_v, registered
- oDPLBUF_BUSY  output  PORTS  port tracker not IDLE
- oDPLBUF_ERR  output  3  sticky {collision, double grant, unsolicited data}
- oDPLBUF_COLL_CNT  output  16  saturating collision count

## Operation
- Data path: stage 1 registers the OR of all iLE_DPLBUF_DATA; STAGES-1 further stages follow; the final register ORs in iBIST_DPLBUF_DATA. Valid/req follow the same path; BIST valid/req are ORed in at the final register.
- Per-port tracker FSM, evaluated on input-side signals:
  - IDLE -> GRANTED on iPCIE_DPLBUF_GNT[p].
  - GRANTED -> XFER on the first iLE_DPLBUF_DATA_V[p]; beat counter = 1.
  - XFER: each data_v increments the counter. The BURST-th beat returns the port to IDLE and clears the counter.
  - BURST=1: the first beat goes GRANTED -> IDLE directly.
- Request masking: stage-1 req[p] = iLE_DPLBUF_REQ[p] & state==IDLE & ~iPCIE_DPLBUF_GNT[p]. BIST req is never masked.
- Boundary conditions:
  - A grant in the same cycle as the final beat is legal; the next state is GRANTED.
  - A grant in GRANTED, or in XFER other than the final beat, is a double grant. The state is unchanged.
  - Data_v in IDLE is unsolicited data. The state is unchanged and the beat is still forwarded.
- oDPLBUF_BUSY[p] = (state != IDLE), driven directly from the state register.
- Reset values:
  - All outputs are 0, except oPCIE_DPLBUF_DATA and the internal data stages, which have no reset and are valid only with DATA_V.
  - All trackers reset to IDLE with the counter at 0.
  - A reset mid-burst abandons the burst; no error is raised afterwards for that burst.

## Timing
- LE data/data_v/req -> oPCIE_*: STAGES cycles.
- BIST inputs -> oPCIE_*: 1 cycle.
- iPCIE_DPLBUF_GNT -> oDAT_DPLBUF_GNT: 1 cycle.
- iPCIE_DPLBUF_GNT -> oDPLBUF_BUSY: 1 cycle.
- |iLE_DPLBUF_DATA_V -> oDPLBUF_ANY_DATA_VLD: 1 cycle.
- Error flags and collision count update 1 cycle after the offending input.
- iERR_CLR takes effect on the next edge. If an error occurs in the same cycle as the clear, the error wins: the flag is set and the count is 1.

## Configuration
- DPLBUF_PIPE_CHK_EN defined:
  - The error logic is compiled in.
  - A collision is 2 or more bits of iLE_DPLBUF_DATA_V set in one cycle.
  - oDPLBUF_COLL_CNT increments once per collision cycle and saturates at 16'hFFFF.
- DPLBUF_PIPE_CHK_EN undefined:
  - The error logic is compiled out.
  - oDPLBUF_ERR and oDPLBUF_COLL_CNT are tied to 0 and iERR_CLR is ignored.
  - Tracking and masking are unaffected.

## Structure
- Package dplbuf_pkg holds:
  - the port state enum (IDLE, GRANTED, XFER);
  - ERR_* bit index constants;
  - COLL_CNT_W = 16;
  - the beat counter width, $clog2(BURST+1), as a parameterised function.
- Sub-module dplbuf_port_trk is the per-port FSM, beat counter, req mask and error pulses. It is instantiated PORTS times by a generate loop.

## Test plan
- PORTS=12, STAGES=2, BURST=4. Port 3: req, grant, 4 beats of data 'hA5.. -> oPCIE_DPLBUF_DATA_V[3] pulses 4 cycles, each 2 cycles after the input; BUSY[3] is high from grant+1 to last beat+1; REQ[3] is masked throughout.
- Grant to port 5 in the same cycle as its 4th beat -> port 5 re-enters GRANTED with no error.
- Data_v[0] and data_v[7] asserted together for 3 cycles -> oDPLBUF_ERR[2] set, COLL_CNT=3. Then iERR_CLR -> both read 0.
- Data_v[2] with no grant -> ERR[0] set and the beat is still forwarded. A second grant while GRANTED -> ERR[1] set.
- iRST_n asserted mid-burst (beat 2 of 4) -> all outputs 0 and BUSY 0. After release, a new grant/burst completes cleanly.
- BIST: iBIST_DPLBUF_DATA_V[1] with data 'h1234 -> appears on outputs 1 cycle later, ORed with any concurrent LE data.
- Rebuild without DPLBUF_PIPE_CHK_EN and repeat the collision test -> ERR and COLL_CNT stay 0.
